// File: rtl/traffic_pkg.sv
// Shared types and default timing for the traffic phase scheduler.
// Light and phase encodings here are what the signal heads and debug port see.
package traffic_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      YELLOW = 2'b01,
      RED    = 2'b10
   } light_t;

   typedef enum logic [2:0] {
      A_GRN = 3'd0,
      A_YEL = 3'd1,
      AR_AB = 3'd2,
      B_GRN = 3'd3,
      B_YEL = 3'd4,
      AR_BA = 3'd5,
      WALK  = 3'd6
   } phase_t;

   typedef enum logic {
      DIR_A = 1'b0,
      DIR_B = 1'b1
   } dir_t;

   localparam int GREEN_MIN_DEF = 8;
   localparam int GREEN_MAX_DEF = 32;
   localparam int YELLOW_T_DEF  = 3;
   localparam int ALLRED_T_DEF  = 1;
   localparam int WALK_T_DEF    = 6;
   localparam int CNT_W_DEF     = 6;

   function automatic logic is_green(input phase_t p);
      return (p == A_GRN) || (p == B_GRN);
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: synchronous clear on phase entry, saturation at
// a caller-supplied limit, and an equality compare against a terminal count.
module phase_timer #(
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] lim_i,
   input  logic [CNT_W-1:0] tc_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: clear wins, otherwise count up until the limit
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q < lim_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/traffic_phase_sched.sv
// Timed phase scheduler for a two-street intersection with pedestrian walk.
// Optional emergency preemption is compiled in with EMERG_PREEMPT_EN.
module traffic_phase_sched
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN = GREEN_MIN_DEF,
   parameter int GREEN_MAX = GREEN_MAX_DEF,
   parameter int YELLOW_T  = YELLOW_T_DEF,
   parameter int ALLRED_T  = ALLRED_T_DEF,
   parameter int WALK_T    = WALK_T_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ta,
   input  logic       tb,
   input  logic       ped_req,
`ifdef EMERG_PREEMPT_EN
   input  logic       emg_req,
   input  logic       emg_dir,
`endif
   output logic       ped_ack,
   output logic       walk,
   output logic [1:0] la,
   output logic [1:0] lb,
   output logic [2:0] phase
);

   localparam logic [CNT_W-1:0] GMIN_TC = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_TC = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_TC  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_TC   = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] WALK_TC = CNT_W'(WALK_T - 1);

   phase_t           state_q, state_d, base_s;
   dir_t             next_dir_q, next_dir_d;
   light_t           la_q, la_d, lb_q, lb_d;
   logic             walk_q, walk_d;
   logic             ped_pend_q, ped_pend_d;
   logic             ped_ack_q, ped_ack_d;
   logic             ped_set_s, wait_a_s, wait_b_s, min_ok_s;
   logic             tc_s, clr_s;
   logic [CNT_W-1:0] cnt_s, lim_s, tc_val_s;

   assign wait_a_s  = ta | ped_pend_q;
   assign wait_b_s  = tb | ped_pend_q;
   assign min_ok_s  = (cnt_s >= GMIN_TC);
   assign clr_s     = (state_d != state_q);
   assign ped_set_s = ped_req & ~ped_pend_q & (state_q != WALK);

   // greens saturate at max-out; other phases just run to their terminal count
   assign lim_s = is_green(state_q) ? GMAX_TC : {CNT_W{1'b1}};

   // terminal count for the phase currently held
   always_comb begin
      tc_val_s = GMAX_TC;
      case (state_q)
         A_YEL, B_YEL: tc_val_s = YEL_TC;
         AR_AB, AR_BA: tc_val_s = AR_TC;
         WALK:         tc_val_s = WALK_TC;
         default:      tc_val_s = GMAX_TC;
      endcase
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i    (clk),
      .rst_i    (rst),
      .clr_i    (clr_s),
      .lim_i    (lim_s),
      .tc_val_i (tc_val_s),
      .cnt_o    (cnt_s),
      .tc_o     (tc_s)
   );

   // state register plus registered light/walk/ack outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= A_GRN;
         next_dir_q <= DIR_B;
         ped_pend_q <= 1'b0;
         ped_ack_q  <= 1'b0;
         la_q       <= GREEN;
         lb_q       <= RED;
         walk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         next_dir_q <= next_dir_d;
         ped_pend_q <= ped_pend_d;
         ped_ack_q  <= ped_ack_d;
         la_q       <= la_d;
         lb_q       <= lb_d;
         walk_q     <= walk_d;
      end
   end

   // normal timed sequencing; tc_s doubles as the max-out flag in greens
   always_comb begin
      base_s = state_q;
      case (state_q)
         A_GRN: begin
            if (wait_b_s && ((min_ok_s && !ta) || tc_s)) base_s = A_YEL;
            else                                         base_s = A_GRN;
         end
         A_YEL: begin
            if (tc_s) base_s = AR_AB;
            else      base_s = A_YEL;
         end
         AR_AB: begin
            if (tc_s) base_s = ped_pend_q ? WALK : B_GRN;
            else      base_s = AR_AB;
         end
         B_GRN: begin
            if (wait_a_s && ((min_ok_s && !tb) || tc_s)) base_s = B_YEL;
            else                                         base_s = B_GRN;
         end
         B_YEL: begin
            if (tc_s) base_s = AR_BA;
            else      base_s = B_YEL;
         end
         AR_BA: begin
            if (tc_s) base_s = ped_pend_q ? WALK : A_GRN;
            else      base_s = AR_BA;
         end
         WALK: begin
            if (tc_s) base_s = (next_dir_q == DIR_B) ? B_GRN : A_GRN;
            else      base_s = WALK;
         end
         default: base_s = A_GRN;
      endcase
   end

`ifdef EMERG_PREEMPT_EN
   // emergency overrides: cut the conflicting green, abort walk, hold target green
   always_comb begin
      state_d = base_s;
      if (emg_req) begin
         case (state_q)
            A_GRN: begin
               if (emg_dir) state_d = A_YEL;
               else         state_d = A_GRN;
            end
            B_GRN: begin
               if (!emg_dir) state_d = B_YEL;
               else          state_d = B_GRN;
            end
            AR_AB, AR_BA: begin
               if (tc_s) state_d = emg_dir ? B_GRN : A_GRN;
               else      state_d = state_q;
            end
            WALK:    state_d = (next_dir_q == DIR_B) ? AR_AB : AR_BA;
            default: state_d = base_s;
         endcase
      end else begin
         state_d = base_s;
      end
   end
`else
   // without preemption the timed sequence is final
   always_comb begin
      state_d = base_s;
   end
`endif

   // pedestrian latch and all-red direction bookkeeping
   always_comb begin
      ped_ack_d  = ped_set_s;
      ped_pend_d = ped_pend_q;
      next_dir_d = next_dir_q;
      if ((state_d == WALK) && (state_q != WALK)) begin
         ped_pend_d = 1'b0;
      end else if (ped_set_s) begin
         ped_pend_d = 1'b1;
      end else begin
         ped_pend_d = ped_pend_q;
      end
      if ((state_d == AR_AB) && (state_q != AR_AB)) begin
         next_dir_d = DIR_B;
      end else if ((state_d == AR_BA) && (state_q != AR_BA)) begin
         next_dir_d = DIR_A;
      end else begin
         next_dir_d = next_dir_q;
      end
   end

   // Moore decode of the upcoming state so lights update with phase
   always_comb begin
      la_d   = RED;
      lb_d   = RED;
      walk_d = 1'b0;
      case (state_d)
         A_GRN:   la_d = GREEN;
         A_YEL:   la_d = YELLOW;
         B_GRN:   lb_d = GREEN;
         B_YEL:   lb_d = YELLOW;
         WALK:    walk_d = 1'b1;
         default: walk_d = 1'b0;
      endcase
   end

   assign la      = la_q;
   assign lb      = lb_q;
   assign walk    = walk_q;
   assign ped_ack = ped_ack_q;
   assign phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Self-checking bench for traffic_phase_sched: vector table, corner sequences,
// and a randomized run against a stage/street-level reference model.
module tb_traffic_phase_sched;

   localparam logic [1:0] LG = 2'b00;
   localparam logic [1:0] LY = 2'b01;
   localparam logic [1:0] LR = 2'b10;
   localparam int GMIN = 8, GMAX = 32, YEL = 3, AR = 1, WLK = 6;

   logic       clk = 1'b0;
   logic       rst, ta, tb, ped_req;
   logic       ped_ack, walk;
   logic [1:0] la, lb;
   logic [2:0] phase;
`ifdef EMERG_PREEMPT_EN
   logic       emg_req = 1'b0;
   logic       emg_dir = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   traffic_phase_sched dut (
      .clk     (clk),
      .rst     (rst),
      .ta      (ta),
      .tb      (tb),
      .ped_req (ped_req),
`ifdef EMERG_PREEMPT_EN
      .emg_req (emg_req),
      .emg_dir (emg_dir),
`endif
      .ped_ack (ped_ack),
      .walk    (walk),
      .la      (la),
      .lb      (lb),
      .phase   (phase)
   );

   typedef struct {
      logic       ta;
      logic       tb;
      int         adv;
      logic [1:0] la;
      logic [1:0] lb;
   } vec_t;

   vec_t vt [16];

   // reference model: street (0=A,1=B), stage (0 green,1 yellow,2 all-red,3 walk)
   int   m_str, m_stg, m_t, m_next;
   logic m_pend, m_ack;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input bit check_vals);
      rst = 1'b1; ta = 1'b0; tb = 1'b0; ped_req = 1'b0;
`ifdef EMERG_PREEMPT_EN
      emg_req = 1'b0; emg_dir = 1'b0;
`endif
      tick(1);
      if (check_vals) begin
         chk("reset_la", la, LG);
         chk("reset_lb", lb, LR);
         chk("reset_walk", walk, 0);
         chk("reset_ack", ped_ack, 0);
         chk("reset_phase", phase, 0);
      end
      rst = 1'b0;
   endtask

   task automatic model_reset();
      m_str = 0; m_stg = 0; m_t = 0; m_next = 1; m_pend = 1'b0; m_ack = 1'b0;
   endtask

   task automatic model_step(input logic r, input logic a, input logic b, input logic p);
      bit   own, oth, moved;
      logic pend_n;
      int   nstg, nstr;
      if (r) begin
         model_reset();
         return;
      end
      m_ack  = p && !m_pend && (m_stg != 3);
      pend_n = m_pend | m_ack;
      nstg = m_stg; nstr = m_str; moved = 0;
      case (m_stg)
         0: begin
            own = (m_str == 1) ? b : a;
            oth = ((m_str == 1) ? a : b) | m_pend;
            if (oth && ((m_t + 1 >= GMIN && !own) || (m_t + 1 >= GMAX))) begin
               nstg = 1; moved = 1;
            end
         end
         1: if (m_t + 1 >= YEL) begin
               nstg = 2; m_next = 1 - m_str; moved = 1;
            end
         2: if (m_t + 1 >= AR) begin
               if (m_pend) begin
                  nstg = 3; pend_n = 1'b0;
               end else begin
                  nstg = 0; nstr = 1 - m_str;
               end
               moved = 1;
            end
         default: if (m_t + 1 >= WLK) begin
               nstg = 0; nstr = m_next; moved = 1;
            end
      endcase
      if (moved)            m_t = 0;
      else if (m_stg == 0)  m_t = (m_t + 1 > GMAX - 1) ? GMAX - 1 : m_t + 1;
      else                  m_t = m_t + 1;
      m_stg = nstg; m_str = nstr; m_pend = pend_n;
   endtask

   function automatic logic [1:0] model_light(input int street);
      if (m_str == street && m_stg == 0) return LG;
      if (m_str == street && m_stg == 1) return LY;
      return LR;
   endfunction

   initial begin
      int bad;
      int walks;

      vt[0]  = '{1'b0, 1'b1,  7, LG, LR};
      vt[1]  = '{1'b0, 1'b1,  1, LY, LR};
      vt[2]  = '{1'b0, 1'b1,  2, LY, LR};
      vt[3]  = '{1'b0, 1'b1,  1, LR, LR};
      vt[4]  = '{1'b0, 1'b1,  1, LR, LG};
      vt[5]  = '{1'b0, 1'b1, 40, LR, LG};
      vt[6]  = '{1'b1, 1'b1,  1, LR, LY};
      vt[7]  = '{1'b1, 1'b1,  2, LR, LY};
      vt[8]  = '{1'b1, 1'b1,  1, LR, LR};
      vt[9]  = '{1'b1, 1'b1,  1, LG, LR};
      vt[10] = '{1'b1, 1'b1, 31, LG, LR};
      vt[11] = '{1'b1, 1'b1,  1, LY, LR};
      vt[12] = '{1'b1, 1'b1,  3, LR, LR};
      vt[13] = '{1'b1, 1'b1,  1, LR, LG};
      vt[14] = '{1'b1, 1'b1, 31, LR, LG};
      vt[15] = '{1'b1, 1'b1,  1, LR, LY};

      // table: min-green handoff, indefinite hold, max-out alternation
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) begin
         ta = vt[i].ta;
         tb = vt[i].tb;
         tick(vt[i].adv);
         chk($sformatf("vec%0d_la", i), la, vt[i].la);
         chk($sformatf("vec%0d_lb", i), lb, vt[i].lb);
      end

      // pedestrian request, repeat while pending and during walk
      do_reset(1'b0);
      ped_req = 1'b1;
      tick(1);
      chk("ped_ack_pulse", ped_ack, 1);
      ped_req = 1'b0;
      tick(1);
      chk("ped_ack_drop", ped_ack, 0);
      ped_req = 1'b1;
      tick(1);
      chk("ped_ack_pending", ped_ack, 0);
      ped_req = 1'b0;
      tick(4);
      chk("ped_min_green", la, LG);
      tick(1);
      chk("ped_yellow", la, LY);
      tick(3);
      chk("ped_allred_la", la, LR);
      chk("ped_allred_walk", walk, 0);
      tick(1);
      chk("walk_on", walk, 1);
      chk("walk_la", la, LR);
      chk("walk_lb", lb, LR);
      chk("walk_phase", phase, 6);
      ped_req = 1'b1;
      tick(1);
      chk("ped_ack_walk", ped_ack, 0);
      ped_req = 1'b0;
      tick(4);
      chk("walk_end_hold", walk, 1);
      tick(1);
      chk("walk_off", walk, 0);
      chk("walk_to_b", lb, LG);
      walks = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (walk) walks++;
      end
      chk("single_walk", walks, 0);
      chk("b_hold", lb, LG);

      // reset during B yellow with a pending request
      do_reset(1'b0);
      tb = 1'b1;
      tick(12);
      chk("rb_bgreen", lb, LG);
      ped_req = 1'b1;
      tick(1);
      chk("rb_ack", ped_ack, 1);
      ped_req = 1'b0;
      tb = 1'b0;
      tick(6);
      chk("rb_bmin", lb, LG);
      tick(1);
      chk("rb_byel", lb, LY);
      rst = 1'b1;
      tick(1);
      chk("rb_rst_la", la, LG);
      chk("rb_rst_lb", lb, LR);
      chk("rb_rst_phase", phase, 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (walk || la != LG) bad++;
      end
      chk("rb_no_walk", bad, 0);

`ifdef EMERG_PREEMPT_EN
      // preemption toward B at A green cnt=2
      do_reset(1'b0);
      tick(2);
      emg_req = 1'b1; emg_dir = 1'b1;
      tick(1);
      chk("emg_yel", la, LY);
      tick(3);
      chk("emg_allred", lb, LR);
      tick(1);
      chk("emg_bgreen", lb, LG);
      ta = 1'b1;
      tick(40);
      chk("emg_hold", lb, LG);
      emg_req = 1'b0;
      tick(1);
      chk("emg_release", lb, LY);
`endif

      // randomized run against the reference model
      do_reset(1'b0);
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 11) == 0) ta = ~ta;
         if ($urandom_range(0, 11) == 0) tb = ~tb;
         ped_req = ($urandom_range(0, 15) == 0);
         rst     = ($urandom_range(0, 499) == 0);
         @(posedge clk);
         model_step(rst, ta, tb, ped_req);
         @(negedge clk);
         chk("rnd_la", la, model_light(0));
         chk("rnd_lb", lb, model_light(1));
         chk("rnd_walk", walk, (m_stg == 3) ? 1 : 0);
         chk("rnd_ack", ped_ack, m_ack);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
